// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of TONE_IN in CLK cycles between rising edges
// and classifies it as one of the eight notes C4..C5. A note is reported only
// after STABLE_N consecutive periods land in the same note window.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no reference edge yet; next rising edge starts a measurement
//   MEASURE  | counting since the last rising edge; next edge yields a period
//
// NOTE encoding: 0=C4 1=D 2=E 3=F 4=G 5=A 6=B 7=C5.
module tone_decoder #(
    parameter int SCALE_SHIFT = 0,
    parameter int TOL_SHIFT   = 6,
    parameter int STABLE_N    = 2,
    parameter int TIMEOUT     = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TONE_IN,
    output logic [2:0]  NOTE,
    output logic        NOTE_VALID,
    output logic        NOTE_STB,
    output logic        ERR_STB,
    output logic [19:0] PERIOD
);

    localparam logic [19:0] TIMEOUT_C  = 20'(TIMEOUT);
    localparam logic [19:0] TIMEOUT_M1 = 20'(TIMEOUT - 1);
    localparam int          MCNT_W     = $clog2(STABLE_N + 1);
    localparam logic [MCNT_W-1:0] STABLE_C = MCNT_W'(STABLE_N);
    localparam logic [MCNT_W-1:0] MCNT_ONE = MCNT_W'(1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Nominal full period of note k in CLK cycles, scaled down by SCALE_SHIFT.
    function automatic logic [19:0] nominal(input logic [2:0] k);
        logic [19:0] n;
        case (k)
            3'd0:    n = 20'd382219;
            3'd1:    n = 20'd340530;
            3'd2:    n = 20'd303370;
            3'd3:    n = 20'd286344;
            3'd4:    n = 20'd255102;
            3'd5:    n = 20'd227272;
            3'd6:    n = 20'd202429;
            default: n = 20'd191204;
        endcase
        return n >> SCALE_SHIFT;
    endfunction

    // Returns {hit, note}. Note windows are disjoint so at most one bin can hit.
    function automatic logic [3:0] classify(input logic [19:0] p);
        logic [3:0]  res;
        logic [19:0] nom;
        logic [19:0] tol;
        logic [19:0] diff;
        res  = 4'b0000;
        nom  = 20'd0;
        tol  = 20'd0;
        diff = 20'd0;
        for (int k = 0; k < 8; k++) begin
            nom  = nominal(3'(k));
            tol  = nom >> TOL_SHIFT;
            diff = (p >= nom) ? (p - nom) : (nom - p);
            if (diff <= tol) begin
                res = {1'b1, 3'(k)};
            end
        end
        return res;
    endfunction

    // Input synchronizer and edge detector
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;
    logic rise_q,  rise_d;

    // Measurement and classification state
    state_t             state_q, state_d;
    logic [19:0]        cnt_q, cnt_d;
    logic [19:0]        period_q, period_d;
    logic [2:0]         note_q, note_d;
    logic               valid_q, valid_d;
    logic               note_stb_q, note_stb_d;
    logic               err_stb_q, err_stb_d;
    logic [2:0]         cand_q, cand_d;
    logic [MCNT_W-1:0]  mcnt_q, mcnt_d;

    logic [19:0]        meas_p;
    logic               match_hit;
    logic [2:0]         match_idx;

    // Two-stage synchronizer followed by the edge register; rise is a registered one-cycle pulse.
    always_comb begin
        sync1_d = TONE_IN;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        rise_d  = sync2_q & ~edge_q;
    end

    // Synchronizer and edge detect flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            rise_q  <= rise_d;
        end
    end

    // Candidate period for the edge arriving now, and which note window (if any) it falls in.
    always_comb begin
        meas_p                 = cnt_q + 20'd1;
        {match_hit, match_idx} = classify(meas_p);
    end

    // Edge-to-edge counter: cleared on every rise, otherwise counts up and parks at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (rise_q) begin
            cnt_d = 20'd0;
        end else if (cnt_q < TIMEOUT_C) begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    // Next-state and output logic: a rise in MEASURE takes precedence over the timeout.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        note_d     = note_q;
        valid_d    = valid_q;
        note_stb_d = 1'b0;
        err_stb_d  = 1'b0;
        cand_d     = cand_q;
        mcnt_d     = mcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (rise_q) begin
                    state_d = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (rise_q) begin
                    period_d = meas_p;
                    if (!match_hit) begin
                        err_stb_d = 1'b1;
                        mcnt_d    = '0;
                        valid_d   = 1'b0;
                    end else begin
                        if (match_idx == cand_q) begin
                            if (mcnt_q < STABLE_C) begin
                                mcnt_d = mcnt_q + MCNT_ONE;
                            end
                        end else begin
                            cand_d  = match_idx;
                            mcnt_d  = MCNT_ONE;
                            valid_d = 1'b0;
                        end
                        // Lock: only announce when the reported note actually changes.
                        if (mcnt_d == STABLE_C) begin
                            note_d     = cand_d;
                            valid_d    = 1'b1;
                            note_stb_d = !valid_q || (note_q != cand_d);
                        end
                    end
                end else if (cnt_q == TIMEOUT_M1) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    mcnt_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 20'd0;
            period_q   <= 20'd0;
            note_q     <= 3'd0;
            valid_q    <= 1'b0;
            note_stb_q <= 1'b0;
            err_stb_q  <= 1'b0;
            cand_q     <= 3'd0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            note_q     <= note_d;
            valid_q    <= valid_d;
            note_stb_q <= note_stb_d;
            err_stb_q  <= err_stb_d;
            cand_q     <= cand_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign NOTE       = note_q;
    assign NOTE_VALID = valid_q;
    assign NOTE_STB   = note_stb_q;
    assign ERR_STB    = err_stb_q;
    assign PERIOD     = period_q;

endmodule
